bcd_display_scan: RTL and testbench



---
 rtl/bcd_disp_pkg.sv | 23 ++
 rtl/bcd_to_seg7.sv | 13 +
 rtl/bcd_display_scan.sv | 116 +++++++++++
 tb/tb_bcd_display_scan.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD display scanner.
//   state_t   : scan FSM states (SHOW drives one digit, GAP keeps all dark)
//   SEG_*     : active-low segment patterns {g,f,e,d,c,b,a}
//   AN_OFF    : all anodes disabled (active-low)
//   SEG_LUT   : 16-entry code -> segment table; codes A-F map to a dash
package bcd_disp_pkg;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Entry n sits at index n; leftmost element of the concatenation is index 15.
  localparam logic [15:0][6:0] SEG_LUT = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to common-anode 7-segment decoder.
//   code  : 4-bit digit code (A-F are illegal and show a dash)
//   seg_c : active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_c
);

  assign seg_c = SEG_LUT[code];

endmodule

// File: rtl/bcd_display_scan.sv
// Snapshots four BCD digits on a load strobe and time-multiplexes them onto
// one common-anode 7-segment bus with a dark gap between digits.
//   clk, rst        : clock, synchronous active-high reset
//   load_i          : snapshot strobe, samples Qdata* at the edge
//   Qdata3_i..0_i   : BCD digits, 3 is most significant
//   an_o            : active-low anode enables, bit n selects digit n
//   seg_o           : active-low segments {g,f,e,d,c,b,a}
//   frame_o         : one-cycle pulse on the last cycle digit 3 is shown
// Optional macro LEADING_ZERO_BLANK_EN: leading zero digits 3..1 stay dark
// in their slots (digit 0 is always shown; slot timing is unchanged).
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GAP_CYC  = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] Qdata3_i,
  input  logic [3:0] Qdata2_i,
  input  logic [3:0] Qdata1_i,
  input  logic [3:0] Qdata0_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       frame_o
);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [3:0][3:0]   snap;
  logic [3:0]        an_nxt;
  logic [6:0]        seg_nxt;
  logic              frame_nxt;
  logic [6:0]        dec_c;
  logic              blank_c;

  // Single decoder on the currently selected snapshot digit.
  bcd_to_seg7 u_dec (
    .code  (snap[idx]),
    .seg_c (dec_c)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Blank when this digit and every more significant digit are zero.
  always_comb begin
    blank_c = 1'b0;
    case (idx)
      2'd3:    blank_c = (snap[3] == 4'd0);
      2'd2:    blank_c = (snap[3] == 4'd0) && (snap[2] == 4'd0);
      2'd1:    blank_c = (snap[3] == 4'd0) && (snap[2] == 4'd0) && (snap[1] == 4'd0);
      default: blank_c = 1'b0;
    endcase
  end
`else
  assign blank_c = 1'b0;
`endif

  // Next state and next registered outputs, derived from the present state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    idx_nxt   = idx;
    an_nxt    = AN_OFF;
    seg_nxt   = SEG_BLANK;
    frame_nxt = 1'b0;
    case (state)
      SHOW: begin
        if (!blank_c) begin
          an_nxt  = ~(4'b0001 << idx);
          seg_nxt = dec_c;
        end
        if (cnt == SHOW_LAST) begin
          cnt_nxt   = '0;
          state_nxt = GAP;
          frame_nxt = (idx == 2'd3);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
          state_nxt = SHOW;
        end
      end
      default: state_nxt = SHOW;
    endcase
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SHOW;
      cnt     <= '0;
      idx     <= 2'd0;
      snap    <= '0;
      an_o    <= AN_OFF;
      seg_o   <= SEG_BLANK;
      frame_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      an_o    <= an_nxt;
      seg_o   <= seg_nxt;
      frame_o <= frame_nxt;
      if (load_i) snap <= {Qdata3_i, Qdata2_i, Qdata1_i, Qdata0_i};
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan with SCAN_DIV=4, GAP_CYC=1.
// A slot-arithmetic reference model predicts every output cycle; a few
// literal expectations pin the model to hand-computed values.
module tb_bcd_display_scan;

  localparam int SD     = 4;
  localparam int GC     = 1;
  localparam int SLOT   = SD + GC;
  localparam int PERIOD = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_i;
  logic [3:0] q3, q2, q1, q0;
  logic [3:0] an_o;
  logic [6:0] seg_o;
  logic       frame_o;

  int checks   = 0;
  int failures = 0;

  bcd_display_scan #(.SCAN_DIV(SD), .GAP_CYC(GC), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_i),
    .Qdata3_i (q3),
    .Qdata2_i (q2),
    .Qdata1_i (q1),
    .Qdata0_i (q0),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'h40;  4'd1: dec = 7'h79;  4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;  4'd4: dec = 7'h19;  4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;  4'd7: dec = 7'h78;  4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;  default: dec = 7'h3F;
    endcase
  endfunction

  // Reference model: output after each edge from the edge count since reset.
  logic [3:0] msnap [4];
  int         t      = 0;
  bit         mvalid = 1'b0;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_frame;

  always @(posedge clk) begin
    if (rst) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_frame = 1'b0;
      for (int j = 0; j < 4; j++) msnap[j] = 4'd0;
      t = 0; mvalid = 1'b1;
    end else begin
      int  p, slot, w;
      bit  blank;
      p    = t % PERIOD;
      slot = p / SLOT;
      w    = p % SLOT;
      exp_an = 4'hF; exp_seg = 7'h7F;
      exp_frame = (slot == 3) && (w == SD - 1);
      if (w < SD) begin
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot != 0) begin
          blank = 1'b1;
          for (int j = slot; j < 4; j++) if (msnap[j] != 4'd0) blank = 1'b0;
        end
`endif
        if (!blank) begin
          exp_an = ~(4'(1) << slot);
          exp_seg = dec(msnap[slot]);
        end
      end
      if (load_i) begin
        msnap[3] = q3; msnap[2] = q2; msnap[1] = q1; msnap[0] = q0;
      end
      t++;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_an", int'(an_o), int'(exp_an));
      chk("model_seg", int'(seg_o), int'(exp_seg));
      chk("model_frame", int'(frame_o), int'(exp_frame));
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Reset, then release with a load on the first edge (edge 1 completes here).
  task automatic restart_load(input logic [3:0] a3, a2, a1, a0);
    rst = 1'b1; load_i = 1'b0;
    step();
    rst = 1'b0; load_i = 1'b1;
    q3 = a3; q2 = a2; q1 = a1; q0 = a0;
    step();
    load_i = 1'b0;
  endtask

  initial begin
    int frames;
    rst = 1'b1; load_i = 1'b0; q3 = 4'd0; q2 = 4'd0; q1 = 4'd0; q0 = 4'd0;
    step(2);
    chk("reset_an", int'(an_o), 'hF);
    chk("reset_seg", int'(seg_o), 'h7F);
    chk("reset_frame", int'(frame_o), 0);

    // Load 1,2,3,4 on the first edge after reset; walk one frame.
    restart_load(4'd1, 4'd2, 4'd3, 4'd4);
    chk("first_an", int'(an_o), 'hE);
    chk("first_seg_old_snap", int'(seg_o), 'h40);
    frames = 0;
    for (int n = 2; n <= 21; n++) begin
      step();
      if (frame_o) frames++;
      if (n == 2)  begin chk("d0_an", int'(an_o), 'hE); chk("d0_seg", int'(seg_o), 'h19); end
      if (n == 5)  begin chk("gap_an", int'(an_o), 'hF); chk("gap_seg", int'(seg_o), 'h7F); end
      if (n == 7)  begin chk("d1_an", int'(an_o), 'hD); chk("d1_seg", int'(seg_o), 'h30); end
      if (n == 12) begin chk("d2_an", int'(an_o), 'hB); chk("d2_seg", int'(seg_o), 'h24); end
      if (n == 19) begin
        chk("d3_an", int'(an_o), 'h7); chk("d3_seg", int'(seg_o), 'h79);
        chk("d3_frame", int'(frame_o), 1);
      end
    end
    chk("frames_per_period", frames, 1);

    // Illegal code on digit 0 shows a dash.
    restart_load(4'd5, 4'd5, 4'd5, 4'hC);
    step();
    chk("dash_an", int'(an_o), 'hE);
    chk("dash_seg", int'(seg_o), 'h3F);

    // Reset mid digit-2 window, then scan restarts with a cleared snapshot.
    restart_load(4'd1, 4'd2, 4'd3, 4'd4);
    step(10);
    chk("pre_rst_an", int'(an_o), 'hB);
    rst = 1'b1;
    step();
    chk("midrst_an", int'(an_o), 'hF);
    chk("midrst_seg", int'(seg_o), 'h7F);
    rst = 1'b0;
    step();
    chk("restart_an", int'(an_o), 'hE);
    chk("restart_seg", int'(seg_o), 'h40);

    // Leading-zero pattern 0,0,7,0.
    restart_load(4'd0, 4'd0, 4'd7, 4'd0);
    step(5);
    chk("lz_d1_an", int'(an_o), 'hD);
    chk("lz_d1_seg", int'(seg_o), 'h78);
    step(5);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d2_an", int'(an_o), 'hF);
    chk("lz_d2_seg", int'(seg_o), 'h7F);
`else
    chk("lz_d2_an", int'(an_o), 'hB);
    chk("lz_d2_seg", int'(seg_o), 'h40);
`endif

    // Randomized loads, digit values biased toward zero, occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      load_i = ($urandom_range(0, 5) == 0);
      q3 = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
      q2 = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
      q1 = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
      q0 = 4'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0; load_i = 1'b1;
    step(60);
    load_i = 1'b0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
